// File: rtl/mux_scan_scheduler.sv
// mux_scan_scheduler: scan sequencer for a 4-digit multiplexed common-anode display.
// Walks digit select 0..3 as BLANK (all dark) then DRIVE (one digit low) per slot.
// Holds a double-buffered 16-bit value; new values take effect only at frame boundaries.
// Optional build macro: LEADING_ZERO_BLANK_EN (darkens leading-zero digits 1..3).
module mux_scan_scheduler #(
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic        load,
  output logic [1:0]  select,
  output logic [3:0]  display,
  output logic [3:0]  digit_nibble,
  output logic        frame_done,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       select_q, select_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       display_q, display_d;
  logic [3:0]       digit_nibble_q, digit_nibble_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic [15:0]      active_q, active_d;
  logic [15:0]      pending_q, pending_d;
  logic             pend_flag_q, pend_flag_d;

  // Per-digit view of the buffer that will be active next cycle, so the
  // nibble output moves in lockstep with select and with frame swaps.
  logic [3:0] nib_w [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign nib_w[gi] = active_d[4*gi +: 4];
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // upper_zero[n]: nibbles n..3 of the active value are all zero. Digit 0 is
  // never blanked, so its flag is tied low. The active buffer only changes
  // on entry to BLANK, so active_q is stable across every DRIVE slot.
  logic [3:0] upper_zero;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lz
      if (gi == 0) begin : g_d0
        assign upper_zero[gi] = 1'b0;
      end else begin : g_dn
        assign upper_zero[gi] = ~|active_q[15:4*gi];
      end
    end
  endgenerate
`endif

  // Next-state logic: slot sequencing, enable parking and buffer handoff.
  always_comb begin
    state_d      = state_q;
    select_d     = select_q;
    timer_d      = timer_q;
    frame_done_d = 1'b0;
    active_d     = active_q;
    pending_d    = pending_q;
    pend_flag_d  = pend_flag_q;

    // A boundary swap reads pend_flag_q, so a load in the boundary cycle
    // lands in pending after the older pending value has moved to active.
    if (load) begin
      pending_d   = value;
      pend_flag_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = BLANK;
          select_d = 2'd0;
          timer_d  = '0;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_d  = IDLE;
          select_d = 2'd0;
          timer_d  = '0;
        end else if (timer_q == BLANK_LAST) begin
          state_d = DRIVE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      DRIVE: begin
        if (!enable) begin
          // Parking takes priority over the frame boundary: no pulse, no swap.
          state_d  = IDLE;
          select_d = 2'd0;
          timer_d  = '0;
        end else if (timer_q == ON_LAST) begin
          state_d = BLANK;
          timer_d = '0;
          if (select_q == 2'd3) begin
            select_d     = 2'd0;
            frame_done_d = 1'b1;
            if (pend_flag_q) begin
              active_d = pending_q;
              if (!load) begin
                pend_flag_d = 1'b0;
              end
            end
          end else begin
            select_d = select_q + 2'd1;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        select_d = 2'd0;
        timer_d  = '0;
      end
    endcase
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    busy_d         = (state_d != IDLE);
    digit_nibble_d = nib_w[select_d];
    display_d      = 4'b1111;
    if (state_d == DRIVE) begin
      display_d = ~(4'b0001 << select_d);
`ifdef LEADING_ZERO_BLANK_EN
      if (upper_zero[select_d]) begin
        display_d = 4'b1111;
      end
`endif
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      select_q       <= 2'd0;
      timer_q        <= '0;
      display_q      <= 4'b1111;
      digit_nibble_q <= 4'd0;
      frame_done_q   <= 1'b0;
      busy_q         <= 1'b0;
      active_q       <= 16'd0;
      pending_q      <= 16'd0;
      pend_flag_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      select_q       <= select_d;
      timer_q        <= timer_d;
      display_q      <= display_d;
      digit_nibble_q <= digit_nibble_d;
      frame_done_q   <= frame_done_d;
      busy_q         <= busy_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pend_flag_q    <= pend_flag_d;
    end
  end

  assign select       = select_q;
  assign display      = display_q;
  assign digit_nibble = digit_nibble_q;
  assign frame_done   = frame_done_q;
  assign busy         = busy_q;

endmodule

// File: doc/mux_scan_scheduler.md
Name: mux_scan_scheduler

Overview:
Sequences the 4-digit multiplexed CL341AH display. The block steps the digit select through 0..3 with a programmable on-time per digit and a blanking gap between digits to suppress ghosting. It holds a double-buffered 16-bit display value and presents the active digit's nibble to the segment decoder. Frame-synchronous value updates keep a digit from tearing mid-frame.

Parameters:
ON_CYCLES, 50000, clk cycles a digit is driven per slot (must be >= 1)
BLANK_CYCLES, 500, clk cycles all digits are off between slots (must be >= 1)
CNT_W, 16, width of the slot timer (must hold max(ON_CYCLES, BLANK_CYCLES) - 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  1 = scan running; 0 = display dark, scheduler parked
value  input  16  4 BCD/hex nibbles; value[3:0] is digit 0 (rightmost)
load  input  1  single-cycle strobe: capture value into the pending buffer
select  output  2  index of the current digit slot
display  output  4  digit enables, active-low, one-hot-low when driving (digit n -> bit n low)
digit_nibble  output  4  nibble of the active buffer for the current select
frame_done  output  1  one-cycle pulse when slot 3 finishes DRIVE
busy  output  1  1 whenever state != IDLE

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, select=0, display=4'b1111, digit_nibble=0, frame_done=0, busy=0, timer=0. The active and pending buffers are cleared to 0, and the pending flag is cleared.
- States: IDLE, BLANK, DRIVE.
- IDLE: display=1111. If enable=1, go to BLANK on the next cycle with select=0 and timer=0.
- BLANK: display=1111 for exactly BLANK_CYCLES cycles. Then go to DRIVE with timer=0.
- DRIVE: display = ~(1<<select) for exactly ON_CYCLES cycles. Then:
  - select < 3: select increments and the state goes to BLANK.
  - select = 3: select wraps to 0, frame_done=1 for one cycle, the state goes to BLANK, and the frame-boundary buffer update applies.
- Frame period is 4*(BLANK_CYCLES+ON_CYCLES) cycles.
- Buffers:
  - load=1 copies value into the pending buffer and sets the pending flag. A later load before the frame boundary overwrites the pending buffer (last wins).
  - At the frame boundary (DRIVE exit with select=3), if pending is set, the active buffer takes the pending buffer and pending clears.
  - If load is asserted in that same boundary cycle, the new value goes to pending and pending stays set. The older pending value is transferred to the active buffer.
- digit_nibble = active[4*select+3 : 4*select], registered in step with select. It is valid for the whole BLANK+DRIVE of that slot.
- enable deasserted in BLANK or DRIVE:
  - The next cycle is IDLE, with display=1111, select=0, timer=0, and frame_done=0.
  - No frame_done is emitted.
  - Buffers and the pending flag are retained.
- reset asserted mid-scan: the next cycle matches the reset values regardless of enable or load.
- Display never has more than one bit low. There is always >= BLANK_CYCLES cycles of 1111 between two different low bits.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: during DRIVE, digit n (n = 1..3) stays dark (display=1111) if active nibbles n..3 are all zero. Digit 0 is always driven. Slot timing, select, and frame_done are unchanged.
- Not defined: all four digits are always driven.

Test Plan:
- Reset and enable with ON_CYCLES=4, BLANK_CYCLES=2: reset 3 cycles, then enable=1 -> the display sequence repeats 1111 x2, 1110 x4, 1111 x2, 1101 x4, 1111 x2, 1011 x4, 1111 x2, 0111 x4. frame_done pulses once, at the slot-3 DRIVE exit, and the sequence repeats.
- Buffer update: load value=16'h1234 mid-frame -> digit_nibble stays at the old buffer until frame_done, then shows 4,3,2,1 for select 0,1,2,3 in the next frame.
- Load races: load 16'hAAAA then 16'h5555 in one frame -> the next frame shows 5 on every digit. A load of 16'h7777 coincident with the boundary cycle -> that next frame still shows 5, and the following frame shows 7.
- Disable mid-DRIVE (select=2): enable=0 -> next cycle display=1111, select=0, busy=0, no frame_done. Re-enable -> restarts at BLANK with select=0.
- Reset mid-DRIVE with load=1 in the same cycle -> next cycle all outputs at reset values, active buffer = 0, pending clear.
- LEADING_ZERO_BLANK_EN defined with value=16'h0050 -> digits 3 and 2 stay 1111 in their DRIVE slots; digit 1 is driven (nibble 5) and digit 0 is driven (nibble 0). value=0 -> only digit 0 is driven.
